// File: rtl/sprite_line_eval_pkg.sv
// Shared types and constants for the per-scanline sprite evaluator.
// Holds the evaluator state encoding, sprite heights and OAM byte offsets.
package sprite_line_eval_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN_Y,
        ST_EVAL,
        ST_COPY,
        ST_FINISH
    } eval_state_e;

    localparam int SPRITE_H_SHORT = 8;
    localparam int SPRITE_H_TALL  = 16;

    // Byte layout of one 4-byte OAM record
    localparam logic [1:0] OFS_Y    = 2'd0;
    localparam logic [1:0] OFS_TILE = 2'd1;
    localparam logic [1:0] OFS_ATTR = 2'd2;
    localparam logic [1:0] OFS_X    = 2'd3;

    function automatic int sprite_height(input logic tall);
        return tall ? SPRITE_H_TALL : SPRITE_H_SHORT;
    endfunction

endpackage

// File: rtl/sprite_line_eval_if.sv
// Bus bundle for the sprite evaluator: line request/status, primary OAM read
// port and secondary OAM write port. The master side is the PPU/RAM system.
interface sprite_line_eval_if #(
    parameter int OAM_ENTRIES  = 64,
    parameter int MAX_PER_LINE = 8,
    parameter int LINE_W       = 9
);
    localparam int OAM_AW = $clog2(OAM_ENTRIES * 4);
    localparam int SEC_AW = $clog2(MAX_PER_LINE * 4);
    localparam int CNT_W  = $clog2(MAX_PER_LINE + 1);

    logic              start;
    logic [LINE_W-1:0] line;
    logic              tall;
    logic              enable;
    logic [OAM_AW-1:0] oam_addr;
    logic [7:0]        oam_data;
    logic              sec_wren;
    logic [SEC_AW-1:0] sec_addr;
    logic [7:0]        sec_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output start, line, tall, enable, oam_data,
        input  oam_addr, sec_wren, sec_addr, sec_data, busy, done, count, overflow
    );

    modport slave (
        input  start, line, tall, enable, oam_data,
        output oam_addr, sec_wren, sec_addr, sec_data, busy, done, count, overflow
    );

endinterface

// File: rtl/sprite_line_eval.sv
// Per-scanline sprite evaluator: clears secondary OAM, scans primary OAM and
// copies up to MAX_PER_LINE sprites covering the requested line.
module sprite_line_eval
    import sprite_line_eval_pkg::*;
#(
    parameter int OAM_ENTRIES  = 64,
    parameter int MAX_PER_LINE = 8,
    parameter int LINE_W       = 9
) (
    input  logic                    clock,
    input  logic                    reset,
    sprite_line_eval_if.slave       bus
);

    localparam int ENTRY_W = $clog2(OAM_ENTRIES);
    localparam int SLOT_W  = $clog2(MAX_PER_LINE);
    localparam int SEC_AW  = SLOT_W + 2;
    localparam int CNT_W   = $clog2(MAX_PER_LINE + 1);

    eval_state_e        state, state_next;
    logic [LINE_W-1:0]  line_q;
    logic               tall_q;
    logic               enable_q;
    logic [ENTRY_W-1:0] entry_idx;
    logic [1:0]         byte_idx;
    logic [SEC_AW-1:0]  clr_idx;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;

    logic [LINE_W-1:0]  diff;
    logic               hit;
    logic               last_entry;
    logic               full;
    logic [SLOT_W-1:0]  slot;

    // A Y below the line wraps to a large difference, so it can never hit.
    assign diff       = line_q - LINE_W'(bus.oam_data);
    assign hit        = diff < LINE_W'(sprite_height(tall_q));
    assign last_entry = &entry_idx;
    assign full       = count_q == CNT_W'(MAX_PER_LINE);
    assign slot       = count_q[SLOT_W-1:0];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        state_next   = state;
        bus.oam_addr = '0;
        bus.sec_wren = 1'b0;
        bus.sec_addr = '0;
        bus.sec_data = '0;
        case (state)
            ST_IDLE: begin
                if (bus.start) state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                bus.sec_wren = 1'b1;
                bus.sec_addr = clr_idx;
                bus.sec_data = 8'hFF;
                if (&clr_idx) state_next = enable_q ? ST_SCAN_Y : ST_FINISH;
            end
            ST_SCAN_Y: begin
                bus.oam_addr = {entry_idx, OFS_Y};
                state_next   = ST_EVAL;
            end
            ST_EVAL: begin
                if (hit && !full) begin
                    bus.sec_wren = 1'b1;
                    bus.sec_addr = {slot, OFS_Y};
                    bus.sec_data = bus.oam_data;
                    bus.oam_addr = {entry_idx, OFS_TILE};
                    state_next   = ST_COPY;
                end else if (hit) begin
                    state_next = ST_FINISH;
                end else begin
                    state_next = last_entry ? ST_FINISH : ST_SCAN_Y;
                end
            end
            ST_COPY: begin
                bus.sec_wren = 1'b1;
                bus.sec_addr = {slot, byte_idx};
                bus.sec_data = bus.oam_data;
                if (byte_idx != OFS_X) bus.oam_addr = {entry_idx, byte_idx + 2'd1};
                else                   state_next   = last_entry ? ST_FINISH : ST_SCAN_Y;
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            line_q     <= '0;
            tall_q     <= 1'b0;
            enable_q   <= 1'b0;
            entry_idx  <= '0;
            byte_idx   <= '0;
            clr_idx    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        line_q     <= bus.line;
                        tall_q     <= bus.tall;
                        enable_q   <= bus.enable;
                        entry_idx  <= '0;
                        byte_idx   <= OFS_TILE;
                        clr_idx    <= '0;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                ST_CLEAR: clr_idx <= clr_idx + SEC_AW'(1);
                ST_EVAL: begin
                    if (hit && full)     overflow_q <= 1'b1;
                    else if (hit)        byte_idx   <= OFS_TILE;
                    else if (!last_entry) entry_idx <= entry_idx + ENTRY_W'(1);
                end
                ST_COPY: begin
                    if (byte_idx == OFS_X) begin
                        count_q <= count_q + CNT_W'(1);
                        if (!last_entry) entry_idx <= entry_idx + ENTRY_W'(1);
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = state != ST_IDLE;
    assign bus.done     = state == ST_FINISH;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_sprite_line_eval.sv
// Directed bench for sprite_line_eval: OAM RAM and secondary OAM are modelled
// here, each scenario has hand-computed results and cycle counts.
module tb_sprite_line_eval;

    localparam int OAM_ENTRIES  = 64;
    localparam int MAX_PER_LINE = 8;
    localparam int LINE_W       = 9;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sprite_line_eval_if #(
        .OAM_ENTRIES(OAM_ENTRIES), .MAX_PER_LINE(MAX_PER_LINE), .LINE_W(LINE_W)
    ) bus ();

    sprite_line_eval #(
        .OAM_ENTRIES(OAM_ENTRIES), .MAX_PER_LINE(MAX_PER_LINE), .LINE_W(LINE_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] oam_mem [256];
    logic [7:0] sec_mem [32];
    int         wr_total = 0;

    // Primary OAM read has one cycle latency; secondary OAM captures writes
    always @(posedge clock) begin
        bus.oam_data <= oam_mem[bus.oam_addr];
        if (bus.sec_wren) begin
            sec_mem[bus.sec_addr] <= bus.sec_data;
            wr_total <= wr_total + 1;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_oam();
        for (int n = 0; n < OAM_ENTRIES; n++) begin
            oam_mem[4*n]   = 8'hF0;
            oam_mem[4*n+1] = 8'(8'h40 + n);
            oam_mem[4*n+2] = 8'(8'h80 + n);
            oam_mem[4*n+3] = 8'(8'hC0 + n);
        end
    endtask

    task automatic run_line(input int line, input bit tall, input bit en, input int poke_at,
                            output int cycles, output int writes, output bit done_ok);
        int w0;
        for (int i = 0; i < 32; i++) sec_mem[i] = 8'h00;
        @(negedge clock);
        bus.line   = LINE_W'(line);
        bus.tall   = tall;
        bus.enable = en;
        bus.start  = 1'b1;
        w0 = wr_total;
        @(negedge clock);
        bus.start = 1'b0;
        cycles  = 0;
        done_ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.busy) cycles++;
            bus.start = (poke_at > 0) && (cycles == poke_at);
            if (bus.done) begin
                done_ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        writes = wr_total - w0;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    int cycles, writes, bad;
    bit done_ok, found, done_seen;

    initial begin
        bus.start = 1'b0; bus.line = '0; bus.tall = 1'b0; bus.enable = 1'b0;
        fill_oam();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_busy",     bus.busy, 0);
        check("reset_done",     bus.done, 0);
        check("reset_count",    bus.count, 0);
        check("reset_overflow", bus.overflow, 0);
        check("reset_wren",     bus.sec_wren, 0);
        check("reset_oam_addr", bus.oam_addr, 0);
        reset = 1'b0;

        // Rendering disabled: clear only
        run_line(20, 0, 0, 0, cycles, writes, done_ok);
        check("clr_done",   done_ok, 1);
        check("clr_cycles", cycles, 33);
        check("clr_writes", writes, 32);
        bad = 0;
        for (int i = 0; i < 32; i++) if (sec_mem[i] !== 8'hFF) bad++;
        check("clr_all_ff",   bad, 0);
        check("clr_count",    bus.count, 0);
        check("clr_overflow", bus.overflow, 0);
        check("clr_done_pulse", bus.done, 0);
        check("clr_idle",     bus.busy, 0);

        // Single hit on entry 5
        oam_mem[20] = 8'd100;
        run_line(103, 0, 1, 0, cycles, writes, done_ok);
        check("hit_done",   done_ok, 1);
        check("hit_cycles", cycles, 164);
        check("hit_writes", writes, 36);
        check("hit_y",      sec_mem[0], 8'd100);
        check("hit_tile",   sec_mem[1], 8'h45);
        check("hit_attr",   sec_mem[2], 8'h85);
        check("hit_x",      sec_mem[3], 8'hC5);
        check("hit_slot1",  sec_mem[4], 8'hFF);
        check("hit_count",  bus.count, 1);
        check("hit_ovf",    bus.overflow, 0);

        // Height boundaries with entry 0 at Y=50
        fill_oam();
        oam_mem[0] = 8'd50;
        run_line(65, 1, 1, 0, cycles, writes, done_ok);
        check("tall65_count", bus.count, 1);
        check("tall65_y",     sec_mem[0], 8'd50);
        check("tall65_cycles", cycles, 164);
        run_line(66, 1, 1, 0, cycles, writes, done_ok);
        check("tall66_count", bus.count, 0);
        check("tall66_cycles", cycles, 161);
        run_line(58, 0, 1, 0, cycles, writes, done_ok);
        check("short58_count", bus.count, 0);
        run_line(57, 0, 1, 0, cycles, writes, done_ok);
        check("short57_count", bus.count, 1);
        run_line(49, 1, 1, 0, cycles, writes, done_ok);
        check("above_y_count", bus.count, 0);

        // Exactly MAX_PER_LINE hits: full but no overflow
        fill_oam();
        for (int n = 0; n < 8; n++) oam_mem[4*n] = 8'd10;
        run_line(12, 0, 1, 0, cycles, writes, done_ok);
        check("full_count",  bus.count, 8);
        check("full_ovf",    bus.overflow, 0);
        check("full_cycles", cycles, 185);

        // Nine hits: overflow stops the scan at entry 8
        oam_mem[32] = 8'd10;
        run_line(12, 0, 1, 0, cycles, writes, done_ok);
        check("ovf_done",   done_ok, 1);
        check("ovf_count",  bus.count, 8);
        check("ovf_flag",   bus.overflow, 1);
        check("ovf_cycles", cycles, 75);
        check("ovf_writes", writes, 64);
        check("ovf_s0_y",   sec_mem[0], 8'd10);
        check("ovf_s0_t",   sec_mem[1], 8'h40);
        check("ovf_s7_y",   sec_mem[28], 8'd10);
        check("ovf_s7_t",   sec_mem[29], 8'h47);
        check("ovf_s7_x",   sec_mem[31], 8'hC7);

        // Y=250 with line 5 must not wrap into a hit; overflow clears on start
        fill_oam();
        oam_mem[0] = 8'd250;
        run_line(5, 0, 1, 0, cycles, writes, done_ok);
        check("nowrap_count",  bus.count, 0);
        check("nowrap_ovf",    bus.overflow, 0);
        check("nowrap_cycles", cycles, 161);

        // Start while busy and start during FINISH are both ignored
        fill_oam();
        oam_mem[20] = 8'd100;
        run_line(103, 0, 1, 10, cycles, writes, done_ok);
        check("poke_busy_cycles", cycles, 164);
        check("poke_busy_count",  bus.count, 1);
        run_line(103, 0, 1, 164, cycles, writes, done_ok);
        check("poke_finish_cycles", cycles, 164);
        check("poke_finish_idle",   bus.busy, 0);

        // Reset in the middle of copying entry 5
        @(negedge clock);
        bus.line = 9'd103; bus.tall = 1'b0; bus.enable = 1'b1; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.sec_wren && bus.sec_addr == 5'd1 && bus.oam_addr == 8'd22) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check("rst_reached_copy", found, 1);
        reset = 1'b1;
        @(negedge clock);
        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);
        check("rst_count", bus.count, 0);
        reset = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            done_seen |= bus.done;
        end
        check("rst_no_done", done_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
